// File: rtl/frame_rate_divider_if.sv
// Signal bundle for frame_rate_divider: control strobes in, frame/channel pulses
// and status out, plus read-only debug taps of the internal state.
interface frame_rate_divider_if #(
    parameter int CYCLE_W = 20,
    parameter int FRAME_W = 5,
    parameter int NUM_CH  = 4
);
    // Handshake: there is no valid/ready back-pressure. run is a level, load and stop
    // are single-cycle strobes sampled on every rising clock edge and always accepted.
    // ch_pulse is a valid-only one-cycle event with no ready.
    logic                        run;
    logic [NUM_CH-1:0]           load;
    logic [NUM_CH-1:0]           stop;
    logic [NUM_CH*FRAME_W-1:0]   div_in;
    logic [NUM_CH-1:0]           mode_in;
    logic                        frame_tick;
    logic [NUM_CH-1:0]           ch_pulse;
    logic [NUM_CH-1:0]           ch_busy;
    logic [CYCLE_W-1:0]          dbg_cyc_cnt;
    logic [NUM_CH-1:0]           dbg_ch_state;

    modport master (
        output run, load, stop, div_in, mode_in,
        input  frame_tick, ch_pulse, ch_busy, dbg_cyc_cnt, dbg_ch_state
    );

    modport slave (
        input  run, load, stop, div_in, mode_in,
        output frame_tick, ch_pulse, ch_busy, dbg_cyc_cnt, dbg_ch_state
    );
endinterface

// File: rtl/frame_rate_divider.sv
// Shared frame prescaler plus NUM_CH independent frame-count channels, each
// producing periodic or one-shot single-cycle pulses.
module frame_rate_divider #(
    parameter int CYCLE_W          = 20,
    parameter int CYCLES_PER_FRAME = 833333,
    parameter int FRAME_W          = 5,
    parameter int NUM_CH           = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    frame_rate_divider_if.slave  bus
);
    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_t;

    localparam logic [CYCLE_W-1:0] CYC_RELOAD = CYCLE_W'(CYCLES_PER_FRAME - 1);

    logic [CYCLE_W-1:0] cyc_cnt;
    logic               frame_tick;
    logic [NUM_CH-1:0]  pulse_vec;
    logic [NUM_CH-1:0]  busy_vec;

    // Prescaler counts down and reloads on the zero cycle; it freezes while run is low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_cnt <= CYC_RELOAD;
        end else if (bus.run) begin
            if (cyc_cnt == '0) begin
                cyc_cnt <= CYC_RELOAD;
            end else begin
                cyc_cnt <= cyc_cnt - CYCLE_W'(1);
            end
        end
    end

    assign frame_tick = (cyc_cnt == '0) && bus.run;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t          state_q, state_d;
        logic [FRAME_W-1:0] count_q, count_d;
        logic [FRAME_W-1:0] div_q, div_d;
        logic               mode_q, mode_d;
        logic               pulse_q, pulse_d;
        logic [FRAME_W-1:0] div_slice;

        assign div_slice = bus.div_in[i*FRAME_W +: FRAME_W];

        always_ff @(posedge clock) begin
            if (!reset) begin
                state_q <= CH_IDLE;
                count_q <= '0;
                div_q   <= '0;
                mode_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                div_q   <= div_d;
                mode_q  <= mode_d;
                pulse_q <= pulse_d;
            end
        end

        // Load beats stop beats tick; a zero divisor parks the channel in idle.
        always_comb begin
            state_d = state_q;
            count_d = count_q;
            div_d   = div_q;
            mode_d  = mode_q;
            pulse_d = 1'b0;
            if (bus.load[i]) begin
                div_d   = div_slice;
                mode_d  = bus.mode_in[i];
                count_d = div_slice;
                state_d = (div_slice != '0) ? CH_ACTIVE : CH_IDLE;
            end else if (bus.stop[i]) begin
                state_d = CH_IDLE;
            end else if (frame_tick && (state_q == CH_ACTIVE)) begin
                if (count_q == FRAME_W'(1)) begin
                    pulse_d = 1'b1;
                    if (mode_q) begin
                        state_d = CH_IDLE;
                    end else begin
                        count_d = div_q;
                    end
                end else begin
                    count_d = count_q - FRAME_W'(1);
                end
            end
        end

        assign pulse_vec[i]        = pulse_q;
        assign busy_vec[i]         = (state_q == CH_ACTIVE);
        assign bus.dbg_ch_state[i] = state_q;
    end

    assign bus.frame_tick  = frame_tick;
    assign bus.ch_pulse    = pulse_vec;
    assign bus.ch_busy     = busy_vec;
    assign bus.dbg_cyc_cnt = cyc_cnt;
endmodule

// File: tb/tb_frame_rate_divider.sv
// Randomised and directed stimulus for frame_rate_divider, checked every cycle
// against a tick-index reference model through an expected-value queue.
module tb_frame_rate_divider;
    localparam int CYCLE_W = 3;
    localparam int CPF     = 4;
    localparam int FRAME_W = 4;
    localparam int NUM_CH  = 2;
    localparam int EXP_W   = 1 + NUM_CH + NUM_CH + CYCLE_W;

    logic clock;
    logic rst_n;

    frame_rate_divider_if #(.CYCLE_W(CYCLE_W), .FRAME_W(FRAME_W), .NUM_CH(NUM_CH)) bus ();

    frame_rate_divider #(
        .CYCLE_W(CYCLE_W), .CYCLES_PER_FRAME(CPF), .FRAME_W(FRAME_W), .NUM_CH(NUM_CH)
    ) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    // reference model: run-cycle count k, global tick index g, per-channel load tick base
    int               m_k;
    int               m_g;
    logic [NUM_CH-1:0] m_act;
    logic [NUM_CH-1:0] m_pulse;
    logic [NUM_CH-1:0] m_os;
    int               m_base [NUM_CH];
    int               m_div  [NUM_CH];

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc_no, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("frame_tick", int'(bus.frame_tick), int'(e[EXP_W-1]));
            check("ch_pulse", int'(bus.ch_pulse), int'(e[EXP_W-2 -: NUM_CH]));
            check("ch_busy", int'(bus.ch_busy), int'(e[EXP_W-2-NUM_CH -: NUM_CH]));
            check("cyc_cnt", int'(bus.dbg_cyc_cnt), int'(e[CYCLE_W-1:0]));
            cyc_no++;
        end
    end

    // driver: apply one cycle of inputs, predict visible outputs, then advance the model
    task automatic step(input logic rst, input logic r, input logic [NUM_CH-1:0] ld,
                        input logic [NUM_CH-1:0] st, input logic [NUM_CH*FRAME_W-1:0] dv,
                        input logic [NUM_CH-1:0] md);
        logic tick;
        logic [NUM_CH-1:0] np;
        logic [CYCLE_W-1:0] cyc_exp;
        rst_n       = rst;
        bus.run     = r;
        bus.load    = ld;
        bus.stop    = st;
        bus.div_in  = dv;
        bus.mode_in = md;
        tick    = r && ((m_k % CPF) == CPF - 1);
        cyc_exp = CYCLE_W'(CPF - 1 - (m_k % CPF));
        exp_q.push_back({tick, m_pulse, m_act, cyc_exp});
        @(posedge clock);
        np = '0;
        if (!rst) begin
            m_k   = 0;
            m_g   = 0;
            m_act = '0;
        end else begin
            if (r) m_k++;
            if (tick) m_g++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ld[i]) begin
                    m_div[i]  = int'(dv[i*FRAME_W +: FRAME_W]);
                    m_os[i]   = md[i];
                    m_base[i] = m_g;
                    m_act[i]  = (m_div[i] != 0);
                end else if (st[i]) begin
                    m_act[i] = 1'b0;
                end else if (tick && m_act[i] && (((m_g - m_base[i]) % m_div[i]) == 0)) begin
                    np[i] = 1'b1;
                    if (m_os[i]) m_act[i] = 1'b0;
                end
            end
        end
        m_pulse = np;
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b1, 1'b1, '0, '0, '0, '0);
    endtask

    task automatic wait_tick_next();
        while ((m_k % CPF) != CPF - 1) idle(1);
    endtask

    initial begin
        m_k = 0; m_g = 0; m_act = '0; m_pulse = '0; m_os = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_base[i] = 0;
            m_div[i]  = 1;
        end
        rst_n = 1'b0; bus.run = 1'b1; bus.load = '0; bus.stop = '0;
        bus.div_in = '0; bus.mode_in = '0;
        repeat (2) @(posedge clock);
        #1;

        // reset held, then periodic div=3 on ch0
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, '0, '0, '0, '0);
        idle(1);
        step(1'b1, 1'b1, 2'b01, '0, {4'd0, 4'd3}, 2'b00);
        idle(40);

        // ch0 periodic div=2, ch1 one-shot div=2 within the same frame
        while ((m_k % CPF) != 0) idle(1);
        step(1'b1, 1'b1, 2'b01, '0, {4'd0, 4'd2}, 2'b00);
        step(1'b1, 1'b1, 2'b10, '0, {4'd2, 4'd0}, 2'b10);
        idle(30);

        // load on the tick cycle, load+stop together, stop alone
        wait_tick_next();
        step(1'b1, 1'b1, 2'b01, '0, {4'd0, 4'd2}, 2'b00);
        idle(20);
        step(1'b1, 1'b1, 2'b01, 2'b01, {4'd0, 4'd3}, 2'b00);
        idle(5);
        step(1'b1, 1'b1, '0, 2'b01, '0, '0);
        idle(20);

        // pause mid-frame
        step(1'b1, 1'b1, 2'b01, '0, {4'd0, 4'd1}, 2'b00);
        idle(5);
        for (int j = 0; j < 10; j++) step(1'b1, 1'b0, '0, '0, '0, '0);
        idle(20);

        // div=0 disables ch1, div=15 periodic on ch0
        step(1'b1, 1'b1, 2'b11, '0, {4'd0, 4'd15}, 2'b00);
        idle(130);

        // reset on the tick cycle where ch0 (div=1) would expire
        step(1'b1, 1'b1, 2'b01, '0, {4'd0, 4'd1}, 2'b00);
        wait_tick_next();
        step(1'b0, 1'b1, '0, '0, '0, '0);
        idle(10);

        // randomised traffic
        for (int j = 0; j < 800; j++) begin
            logic [NUM_CH-1:0] ld, st, md;
            logic [NUM_CH*FRAME_W-1:0] dv;
            for (int i = 0; i < NUM_CH; i++) begin
                ld[i] = ($urandom_range(0, 15) == 0);
                st[i] = ($urandom_range(0, 31) == 0);
                md[i] = 1'($urandom_range(0, 1));
            end
            dv = (NUM_CH*FRAME_W)'($urandom);
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0), ld, st, dv, md);
        end
        idle(2);

        @(negedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_rate_divider.md
Name: frame_rate_divider

Overview:
- Multi-channel frame-rate tick generator for the animation and game-logic path.
- A shared prescaler divides the system clock into a frame tick, nominally 60 Hz from 50 MHz.
- NUM_CH independent channels each count a runtime-loadable number of frames. Each channel then emits a one-cycle pulse, either periodically or as a one-shot.
- Successor to the fixed 15-frame delay counter: parametrised widths, per-channel divisors, pause, stop, one-shot mode and busy status.

Parameters:
- CYCLE_W, 20: width of the cycle prescaler counter.
- CYCLES_PER_FRAME, 833333: clock cycles per frame tick. Legal range is 2 to 2^CYCLE_W.
- FRAME_W, 5: width of the per-channel frame divisor and counter.
- NUM_CH, 4: number of independent channels, 1 to 16.

Ports:
- clock, in, 1: system clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-low; reset clock domain is clock.
- run, in, 1: 1 = prescaler advances; 0 = prescaler frozen, no frame ticks.
- load, in, NUM_CH: per-channel load strobe.
- stop, in, NUM_CH: per-channel stop strobe.
- div_in, in, NUM_CH*FRAME_W: per-channel frame divisor. Channel i uses bits [i*FRAME_W +: FRAME_W].
- mode_in, in, NUM_CH: per-channel mode latched on load; 0 = periodic, 1 = one-shot.
- frame_tick, out, 1: one-cycle pulse per frame (combinational from prescaler state).
- ch_pulse, out, NUM_CH: registered one-cycle pulse when a channel's frame count expires.
- ch_busy, out, NUM_CH: channel active flag, registered.

Behaviour:
- Reset (reset==0 at a clock edge), all synchronous:
  - cyc_cnt <= CYCLES_PER_FRAME-1.
  - Every channel: count <= 0, div <= 0, mode <= 0, active <= 0.
  - ch_pulse <= 0.
  - Consequences: frame_tick reads 0 and ch_busy reads 0 from the first edge. Reset mid-count discards all progress, and no pulse is emitted on the reset edge.
- Prescaler:
  - Applies when run==1: if cyc_cnt==0 it reloads to CYCLES_PER_FRAME-1, otherwise it decrements.
  - When run==0, cyc_cnt holds.
  - frame_tick = (cyc_cnt==0) & run.
  - Period is exactly CYCLES_PER_FRAME clocks while run stays high.
  - The first tick after reset arrives CYCLES_PER_FRAME clocks after reset deasserts.
- Channel i update priority per clock: reset > load > stop > frame tick.
- load[i]==1:
  - div <= div_in slice, mode <= mode_in[i], count <= div_in slice.
  - active <= (div_in slice != 0).
  - A frame_tick in the same cycle is ignored by this channel.
  - Reloading an active channel restarts its count.
- stop[i]==1 (no load): active <= 0. count and div hold; no pulse.
- frame_tick==1 and active, with no load or stop:
  - If count==1: ch_pulse[i] <= 1 on the same edge, so it is visible the cycle after the tick cycle.
    - Periodic: count <= div.
    - One-shot: active <= 0.
  - Otherwise count <= count-1.
- Pulse spacing:
  - A loaded divisor D gives the first pulse D frame ticks after the load cycle; periodic pulses then repeat every D ticks.
  - D==1 periodic gives a pulse on every frame tick.
- ch_pulse[i] is 0 in every cycle not covered above; it is never high for two consecutive cycles.
- Inactive channels ignore frame_tick and hold count.
- div_in == 0: the channel goes or stays inactive; this is the legal way to disable a channel via load.
- Wrap-around:
  - count never decrements below 1 while active.
  - The maximum divisor 2^FRAME_W-1 is fully supported.
  - There is no arithmetic overflow anywhere.
- Channels are fully independent. Simultaneous expiry on several channels gives simultaneous ch_pulse bits.
- ch_busy = active; it reflects a load, stop or one-shot completion one cycle later.
- Compatibility: with run=1, one channel loaded with div=15 in periodic mode, and defaults, the pulse train matches the old 15-frame enable (about 4 Hz).

Test Plan:
- Bench parameters for all scenarios: CYCLES_PER_FRAME=4, FRAME_W=4, NUM_CH=2.
- Prescaler: hold reset low for 3 cycles, release, run=1.
  -> frame_tick high at cycles 4, 8, 12, … after release; frame_tick and ch_busy stay 0 during reset.
- Periodic: load ch0 with div=3, mode=0 one cycle after reset release.
  -> ch_busy[0]=1 next cycle. ch_pulse[0] pulses one cycle after the 3rd, 6th and 9th frame_tick, each pulse exactly one cycle wide.
- One-shot plus concurrency: load ch1 with div=2, mode=1 while ch0 runs with div=2.
  -> Both pulse together after the 2nd tick. ch1 busy drops to 0 and ch1 produces no further pulses; ch0 continues every 2 ticks.
- Priority:
  - load ch0 (div=2) on the exact frame_tick cycle -> that tick is ignored, and the first pulse follows the 2nd subsequent tick.
  - stop and load asserted together -> the load wins.
  - stop alone -> ch_busy=0 and no pulse.
- Pause: deassert run for 10 cycles mid-frame.
  -> cyc_cnt frozen, no frame_tick or ch_pulse during the pause. On resume, the remaining cycles complete the frame; the total period is extended by exactly 10 cycles.
- Edge cases:
  - div=0 load -> ch_busy=0 and never pulses.
  - div=15 periodic -> pulses every 15 ticks.
  - reset asserted with count=1 just before a tick -> no pulse, and all outputs are 0 the next cycle.
